// File: rtl/dsp48a1_biquad_seq_if.sv
// Operand/opmode/result port set between the biquad sequencer and a DSP48A1 wrapper.
// The master drives operands and opmode; the slave returns the accumulator.
interface dsp48a1_biquad_seq_if;
    logic [1:0]  dsp_opmode_x;
    logic [1:0]  dsp_opmode_z;
    logic        dsp_use_preadd;
    logic        dsp_preadd_sub;
    logic        dsp_cryin;
    logic        dsp_postadd_sub;
    logic [17:0] dsp_ain;
    logic [17:0] dsp_bin;
    logic [47:0] dsp_pout;

    modport master (
        output dsp_opmode_x, dsp_opmode_z, dsp_use_preadd, dsp_preadd_sub,
               dsp_cryin, dsp_postadd_sub, dsp_ain, dsp_bin,
        input  dsp_pout
    );

    modport slave (
        input  dsp_opmode_x, dsp_opmode_z, dsp_use_preadd, dsp_preadd_sub,
               dsp_cryin, dsp_postadd_sub, dsp_ain, dsp_bin,
        output dsp_pout
    );
endinterface

// File: rtl/dsp48a1_biquad_seq.sv
// Direct-form-I biquad sequencer: issues five MACs per sample to a DSP48A1 and
// scales/clamps the accumulated result.
//   state  | meaning
//   IDLE   | ready for x[n], DSP inputs zeroed
//   MAC    | one MAC per cycle, step 0..4 (b0 x, b1 x1, b2 x2, -a1 y1, -a2 y2)
//   WAIT   | down-count DSP_LAT cycles until the last product reaches dsp_pout
//   OUT    | result pulse cycle, history already updated
module dsp48a1_biquad_seq #(
    parameter int COEF_FRAC = 16,
    parameter int DSP_LAT   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic signed [17:0]  sample_in_i,
    input  logic                sample_in_valid_i,
    output logic                sample_in_ready_o,
    input  logic signed [17:0]  coef_b0_i,
    input  logic signed [17:0]  coef_b1_i,
    input  logic signed [17:0]  coef_b2_i,
    input  logic signed [17:0]  coef_a1_i,
    input  logic signed [17:0]  coef_a2_i,
    output logic signed [17:0]  sample_out_o,
    output logic                sample_out_valid_o,
    output logic                sample_out_sat_o,
    dsp48a1_biquad_seq_if.master dsp
);
    localparam int CW = (DSP_LAT < 2) ? 1 : $clog2(DSP_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [17:0] x_q, x_d, b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
    logic signed [17:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic signed [17:0] out_q, out_d;
    logic               out_valid_q, out_valid_d, sat_q, sat_d, ready_q, ready_d;
    logic [1:0]         opx_q, opx_d, opz_q, opz_d;
    logic               sub_q, sub_d;
    logic [17:0]        ain_q, ain_d, bin_q, bin_d;

    logic signed [47:0] p_shift;
    logic signed [17:0] y_clamped;
    logic               y_sat;

    // Truncating arithmetic scale back to sample units, then clamp to 18 bits.
    always_comb begin
        p_shift   = $signed(dsp.dsp_pout) >>> COEF_FRAC;
        y_clamped = p_shift[17:0];
        y_sat     = 1'b0;
        if (p_shift > 48'sd131071) begin
            y_clamped = 18'sd131071;
            y_sat     = 1'b1;
        end else if (p_shift < -48'sd131072) begin
            y_clamped = -18'sd131072;
            y_sat     = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        x_d  = x_q;  b0_d = b0_q; b1_d = b1_q; b2_d = b2_q; a1_d = a1_q; a2_d = a2_q;
        x1_d = x1_q; x2_d = x2_q; y1_d = y1_q; y2_d = y2_q;
        out_d       = out_q;
        sat_d       = sat_q;
        out_valid_d = 1'b0;
        ready_d     = ready_q;
        opx_d       = 2'b00;
        opz_d       = 2'b00;
        sub_d       = 1'b0;
        ain_d       = '0;
        bin_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (sample_in_valid_i && ready_q) begin
                    x_d  = sample_in_i;
                    b0_d = coef_b0_i; b1_d = coef_b1_i; b2_d = coef_b2_i;
                    a1_d = coef_a1_i; a2_d = coef_a2_i;
                    state_d = S_MAC;
                    step_d  = 3'd0;
                    ready_d = 1'b0;
                    opx_d   = 2'b01;
                    ain_d   = coef_b0_i;
                    bin_d   = sample_in_i;
                end
            end
            S_MAC: begin
                if (step_q == 3'd4) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(DSP_LAT);
                end else begin
                    step_d = step_q + 3'd1;
                    opx_d  = 2'b01;
                    opz_d  = 2'b10;
                    case (step_q)
                        3'd0:    begin ain_d = b1_q; bin_d = x1_q; end
                        3'd1:    begin ain_d = b2_q; bin_d = x2_q; end
                        3'd2:    begin ain_d = a1_q; bin_d = y1_q; sub_d = 1'b1; end
                        default: begin ain_d = a2_q; bin_d = y2_q; sub_d = 1'b1; end
                    endcase
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    out_d       = y_clamped;
                    sat_d       = y_sat;
                    out_valid_d = 1'b1;
                    x2_d = x1_q; x1_d = x_q;
                    y2_d = y1_q; y1_d = y_clamped;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Clear wins over everything, including a same-cycle accept.
        if (clear_i) begin
            state_d     = S_IDLE;
            step_d      = 3'd0;
            cnt_d       = '0;
            x1_d = '0; x2_d = '0; y1_d = '0; y2_d = '0;
            out_d       = out_q;
            sat_d       = sat_q;
            out_valid_d = 1'b0;
            ready_d     = 1'b1;
            opx_d       = 2'b00;
            opz_d       = 2'b00;
            sub_d       = 1'b0;
            ain_d       = '0;
            bin_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            x_q  <= '0; b0_q <= '0; b1_q <= '0; b2_q <= '0; a1_q <= '0; a2_q <= '0;
            x1_q <= '0; x2_q <= '0; y1_q <= '0; y2_q <= '0;
            out_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            opx_q       <= '0;
            opz_q       <= '0;
            sub_q       <= 1'b0;
            ain_q       <= '0;
            bin_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            x_q  <= x_d;  b0_q <= b0_d; b1_q <= b1_d; b2_q <= b2_d; a1_q <= a1_d; a2_q <= a2_d;
            x1_q <= x1_d; x2_q <= x2_d; y1_q <= y1_d; y2_q <= y2_d;
            out_q       <= out_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            ready_q     <= ready_d;
            opx_q       <= opx_d;
            opz_q       <= opz_d;
            sub_q       <= sub_d;
            ain_q       <= ain_d;
            bin_q       <= bin_d;
        end
    end

    assign sample_in_ready_o   = ready_q;
    assign sample_out_o        = out_q;
    assign sample_out_valid_o  = out_valid_q;
    assign sample_out_sat_o    = sat_q;
    assign dsp.dsp_opmode_x    = opx_q;
    assign dsp.dsp_opmode_z    = opz_q;
    assign dsp.dsp_postadd_sub = sub_q;
    assign dsp.dsp_ain         = ain_q;
    assign dsp.dsp_bin         = bin_q;
    assign dsp.dsp_use_preadd  = 1'b0;
    assign dsp.dsp_preadd_sub  = 1'b0;
    assign dsp.dsp_cryin       = 1'b0;
endmodule

// File: tb/tb_dsp48a1_biquad_seq.sv
// Directed bench for the biquad sequencer against a behavioural DSP48A1
// (accumulator register plus two output stages, 3 edges issue-to-pout).
module tb_dsp48a1_biquad_seq;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clear = 1'b0;
    logic signed [17:0] sample_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [17:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
    logic signed [17:0] sample_out;
    logic               out_valid, out_sat;

    int n_cmp = 0;
    int n_err = 0;

    dsp48a1_biquad_seq_if dsp_bus ();

    dsp48a1_biquad_seq #(.COEF_FRAC(16), .DSP_LAT(3)) dut (
        .clk                (clk),
        .reset              (reset),
        .clear_i            (clear),
        .sample_in_i        (sample_in),
        .sample_in_valid_i  (in_valid),
        .sample_in_ready_o  (in_ready),
        .coef_b0_i          (b0),
        .coef_b1_i          (b1),
        .coef_b2_i          (b2),
        .coef_a1_i          (a1),
        .coef_a2_i          (a2),
        .sample_out_o       (sample_out),
        .sample_out_valid_o (out_valid),
        .sample_out_sat_o   (out_sat),
        .dsp                (dsp_bus)
    );

    always #5 clk = ~clk;

    logic signed [47:0] acc, pd1, mprod, zval, xval;
    always_comb begin
        mprod = 48'($signed(dsp_bus.dsp_ain) * $signed(dsp_bus.dsp_bin));
        zval  = (dsp_bus.dsp_opmode_z == 2'b10) ? acc : 48'sd0;
        xval  = (dsp_bus.dsp_opmode_x == 2'b01) ? mprod : 48'sd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            pd1 <= '0;
            dsp_bus.dsp_pout <= '0;
        end else begin
            acc <= dsp_bus.dsp_postadd_sub ? (zval - xval) : (zval + xval);
            pd1 <= acc;
            dsp_bus.dsp_pout <= pd1;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic set_coefs(input logic signed [17:0] c0, c1, c2, c_a1, c_a2);
        b0 = c0; b1 = c1; b2 = c2; a1 = c_a1; a2 = c_a2;
    endtask

    // One sample end to end; optionally zero the coefs right after accept.
    task automatic run_sample(input string tag, input logic signed [17:0] x,
                              input longint exp_y, input longint exp_sat, input bit zap);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({tag, "_ready_wait"}, 0, 1);
        sample_in = x;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (zap) set_coefs(0, 0, 0, 0, 0);
        check({tag, "_ready_low"}, in_ready, 0);
        n = 1;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 9);
        check({tag, "_y"}, sample_out, exp_y);
        check({tag, "_sat"}, out_sat, exp_sat);
        @(negedge clk);
        check({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        int vcount;
        int vpos [3];
        logic signed [17:0] held;

        // 1: reset values, then idle with no result pulses
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_out", sample_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sat", out_sat, 0);
        check("rst_opx", dsp_bus.dsp_opmode_x, 0);
        check("rst_opz", dsp_bus.dsp_opmode_z, 0);
        check("rst_ain", dsp_bus.dsp_ain, 0);
        check("rst_bin", dsp_bus.dsp_bin, 0);
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("idle_no_valid", vcount, 0);
        check("idle_ready", in_ready, 1);

        // 2: pass-through; coef change after accept must not matter
        set_coefs(18'sh10000, 0, 0, 0, 0);
        run_sample("pass", 18'sd1000, 1000, 0, 1'b1);

        // 3: FIR, three taps of 0.5
        pulse_clear();
        set_coefs(18'sh08000, 18'sh08000, 18'sh08000, 0, 0);
        run_sample("fir0", 18'sd1000, 500, 0, 1'b0);
        run_sample("fir1", 18'sd0, 500, 0, 1'b0);
        run_sample("fir2", 18'sd0, 500, 0, 1'b0);
        run_sample("fir3", 18'sd0, 0, 0, 1'b0);

        // 4: IIR, a1 = -0.5
        pulse_clear();
        set_coefs(18'sh10000, 0, 0, 18'sh38000, 0);
        run_sample("iir0", 18'sd1000, 1000, 0, 1'b0);
        run_sample("iir1", 18'sd0, 500, 0, 1'b0);
        run_sample("iir2", 18'sd0, 250, 0, 1'b0);
        run_sample("iir3", 18'sd0, 125, 0, 1'b0);

        // 5: saturation at both rails
        pulse_clear();
        set_coefs(18'sh1FFFF, 0, 0, 0, 0);
        run_sample("sat_pos", 18'sd131071, 131071, 1, 1'b0);
        run_sample("sat_neg", -18'sd131072, -131072, 1, 1'b0);

        // 6a: valid held high with IIR feedback: results 1000, 1500, 1750 every 10 cycles
        pulse_clear();
        set_coefs(18'sh10000, 0, 0, 18'sh38000, 0);
        @(negedge clk);
        sample_in = 18'sd1000;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("held_ready_low", in_ready, 0);
        vcount = 0;
        for (int i = 2; i <= 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (vcount < 3) vpos[vcount] = i;
                if (vcount == 0) check("held_y0", sample_out, 1000);
                if (vcount == 1) check("held_y1", sample_out, 1500);
                if (vcount == 2) check("held_y2", sample_out, 1750);
                vcount++;
            end
        end
        in_valid = 1'b0;
        check("held_count", vcount, 3);
        check("held_first", vpos[0], 9);
        check("held_gap", vpos[1] - vpos[0], 10);

        // 6b: clear at T+3 aborts the sample; history zeroed, sample_out kept
        while (!in_ready) @(negedge clk);
        held = sample_out;
        sample_in = 18'sd1000;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_ready", in_ready, 1);
        check("clr_opx", dsp_bus.dsp_opmode_x, 0);
        check("clr_ain", dsp_bus.dsp_ain, 0);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("clr_no_valid", vcount, 0);
        check("clr_out_kept", sample_out, held);
        run_sample("post_clr0", 18'sd1000, 1000, 0, 1'b0);
        run_sample("post_clr1", 18'sd0, 500, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
